// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants (S-box, round count), GF(2^8) helpers and the cipher FSM state type
package aes_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [0:31] mix_col(input logic [0:31] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1 ^ a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2 ^ a3) ^ a3,
            xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2};
  endfunction
  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction
endpackage

// File: rtl/aes_enc_round.sv
// aes_enc_round: one combinational forward round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey)
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [0:127] state,
  input  logic [0:127] rk,
  input  logic         skip_mc,
  output logic [0:127] result
);
  logic [0:127] sr, mc;
  for (genvar i = 0; i < 16; i++) begin : g_sr
    assign sr[8*i +: 8] = sub_byte(state[8*((i + 4*(i%4)) % 16) +: 8]);
  end
  for (genvar c = 0; c < 4; c++) begin : g_mc
    assign mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
  end
  assign result = (skip_mc ? sr : mc) ^ rk;
endmodule

// File: rtl/aes_enc_iterative.sv
// aes_enc_iterative: iterative AES encryptor, one round per clk, plaintext/key_sched in over in_valid/in_ready, ciphertext out over out_valid/out_ready
module aes_enc_iterative
  import aes_pkg::*;
#(
  parameter  int NK = 4,
  localparam int NR = nr_of(NK)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:127]             plaintext,
  input  logic [0:128*(NR+1)-1]    key_sched,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:127]             ciphertext,
  output logic                     busy
);
  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $fatal(1, "aes_enc_iterative: NK must be 4, 6 or 8");
  end
  localparam logic [3:0] LAST = 4'(NR);
  state_e       fsm;
  logic [3:0]   round_cnt;
  logic [0:127] state_q, round_out;
  logic [0:127] rk [NR+1];
  logic         last;
  for (genvar i = 0; i <= NR; i++) begin : g_rk
    assign rk[i] = key_sched[128*i +: 128];
  end
  assign last = round_cnt == LAST;
  assign ciphertext = state_q;
  aes_enc_round u_round (
    .state   (state_q),
    .rk      (rk[round_cnt]),
    .skip_mc (last),
    .result  (round_out)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      round_cnt <= '0;
      state_q   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          state_q   <= plaintext ^ rk[0];
          round_cnt <= 4'd1;
          fsm       <= RUN;
          in_ready  <= 1'b0;
          busy      <= 1'b1;
        end
        RUN: begin
          state_q   <= round_out;
          round_cnt <= last ? 4'd0 : round_cnt + 4'd1;
          if (last) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_enc_iterative.sv
// tb_aes_enc_iterative: random and FIPS-197 vectors for NK=4/6/8 against a GF(2^8) reference model
module tb_aes_enc_iterative;
  logic          clk, rst_n;
  logic [2:0]    in_valid, out_ready;
  wire  [2:0]    in_ready, out_valid, busy;
  logic [0:127]  plaintext;
  wire  [0:127]  ct0, ct1, ct2;
  logic [0:1407] ks0;
  logic [0:1663] ks1;
  logic [0:1919] ks2;
  logic [7:0]    sb [256];
  int            n_vec, n_err;
  localparam logic [0:127] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:255] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  aes_enc_iterative #(.NK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .plaintext(plaintext),
    .key_sched(ks0), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .ciphertext(ct0), .busy(busy[0])
  );
  aes_enc_iterative #(.NK(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .plaintext(plaintext),
    .key_sched(ks1), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .ciphertext(ct1), .busy(busy[1])
  );
  aes_enc_iterative #(.NK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .plaintext(plaintext),
    .key_sched(ks2), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .ciphertext(ct2), .busy(busy[2])
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction
  function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1919] ks;
    rc = 8'h01;
    ks = '0;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) w[i] = key[32*i +: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
      ks[32*i +: 32] = w[i];
    end
    return ks;
  endfunction
  function automatic logic [0:127] aes_ref(input logic [0:127] pt, input logic [0:1919] ks, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   m [4];
    logic [0:127] o;
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ ks[8*i +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[4*((i/4 + i%4) % 4) + i%4]];
      if (r < nr)
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) m[j] = t[4*c+j];
          for (int j = 0; j < 4; j++)
            t[4*c+j] = gmul(8'h02, m[j]) ^ gmul(8'h03, m[(j+1)%4]) ^ m[(j+2)%4] ^ m[(j+3)%4];
        end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ ks[128*r + 8*i +: 8];
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
    return o;
  endfunction
  function automatic logic [0:127] get_ct(input int k);
    return k == 0 ? ct0 : k == 1 ? ct1 : ct2;
  endfunction
  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic run(input int k, input logic [0:127] pt, input logic [0:255] key, input int hold,
                     input int inj, input int rst_at, input bit turn, output logic [0:127] ct_o);
    logic [0:1919] full;
    logic [0:127]  exp;
    int            nr, lat;
    nr = 10 + 2*k;
    full = expand(key, 4 + 2*k);
    exp = aes_ref(pt, full, nr);
    ct_o = '0;
    if (k == 0) ks0 = full[0:1407];
    else if (k == 1) ks1 = full[0:1663];
    else ks2 = full;
    for (int i = 0; i < 50 && !in_ready[k]; i++) @(negedge clk);
    check("in_ready_idle", 128'(in_ready[k]), 128'd1);
    plaintext = pt;
    in_valid[k] = 1'b1;
    @(negedge clk);
    in_valid[k] = 1'b0;
    plaintext = rnd128();
    check("busy_run", 128'(busy[k]), 128'd1);
    check("in_ready_run", 128'(in_ready[k]), 128'd0);
    lat = 0;
    while (!out_valid[k] && lat < 40) begin
      if (lat == inj) begin
        in_valid[k] = 1'b1;
        plaintext = rnd128();
      end
      if (lat == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid[k]), 128'd0);
        check("rst_busy", 128'(busy[k]), 128'd0);
        check("rst_in_ready", 128'(in_ready[k]), 128'd1);
        check("rst_ct", get_ct(k), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      in_valid[k] = 1'b0;
      lat++;
    end
    check("latency", 128'(lat), 128'(nr));
    ct_o = get_ct(k);
    check("ct_model", ct_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ct", get_ct(k), exp);
      check("hold_valid", 128'(out_valid[k]), 128'd1);
      check("hold_in_ready", 128'(in_ready[k]), 128'd0);
    end
    out_ready[k] = 1'b1;
    if (turn) begin
      in_valid[k] = 1'b1;
      plaintext = rnd128();
    end
    @(negedge clk);
    out_ready[k] = 1'b0;
    check("handoff_valid", 128'(out_valid[k]), 128'd0);
    check("handoff_busy", 128'(busy[k]), 128'd0);
    check("handoff_in_ready", 128'(in_ready[k]), 128'd1);
  endtask
  initial begin
    logic [0:127] ct;
    logic [7:0]   inv;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '0;
    plaintext = '0;
    ks0 = '0;
    ks1 = '0;
    ks2 = '0;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h01;
      repeat (254) inv = gmul(inv, 8'(b));
      if (b == 0) inv = 8'h00;
      sb[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    repeat (2) @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'h7);
    check("reset_out_valid", 128'(out_valid), 128'h0);
    check("reset_busy", 128'(busy), 128'h0);
    check("reset_ct", ct0 | ct1 | ct2, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, FIPS_PT, FIPS_KEY, 0, -1, -1, 1'b0, ct);
    check("fips_c1", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run(1, FIPS_PT, FIPS_KEY, 0, -1, -1, 1'b0, ct);
    check("fips_c2", ct, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    run(2, FIPS_PT, FIPS_KEY, 0, -1, -1, 1'b0, ct);
    check("fips_c3", ct, 128'h8ea2b7ca516745bfeafc49904b496089);
    run(0, FIPS_PT, FIPS_KEY, 20, -1, -1, 1'b0, ct);
    check("stall_c1", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run(0, rnd128(), {rnd128(), rnd128()}, 0, -1, -1, 1'b0, ct);
    run(0, FIPS_PT, FIPS_KEY, 0, 5, -1, 1'b0, ct);
    check("ignore_c1", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run(0, FIPS_PT, FIPS_KEY, 0, -1, 4, 1'b0, ct);
    run(0, FIPS_PT, FIPS_KEY, 0, -1, -1, 1'b0, ct);
    check("after_rst_c1", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run(0, rnd128(), {rnd128(), rnd128()}, 1, -1, -1, 1'b1, ct);
    run(0, FIPS_PT, FIPS_KEY, 0, -1, -1, 1'b0, ct);
    check("turn_c1", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++)
        run(k, rnd128(), {rnd128(), rnd128()}, int'($urandom_range(0, 2)), -1, -1,
            i < 3 ? 1'($urandom_range(0, 1)) : 1'b0, ct);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
